// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and limits for the input-conditioning blocks (debounce_sync and
// the reusable sync_chain).
//   db_state_t      : debouncer FSM encoding
//   SYNC_STAGES_MIN : smallest synchroniser depth that gives a metastability
//                     settling flop ahead of the first consuming flop
//   DEBOUNCE_MIN    : smallest accepted stability window
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int DEBOUNCE_MIN    = 2;

endpackage : debounce_pkg

// File: rtl/debounce_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// N-flop synchroniser with asynchronous active-low clear. Brings an
// asynchronous level into the clk domain; reused by other input stages.
// Ports:
//   clk   in  1  sampling clock (posedge)
//   clr_n in  1  asynchronous active-low clear, all flops to 0
//   d     in  1  asynchronous input
//   q     out 1  synchronised level (output of the last flop)
// Parameters:
//   STAGES  flop count; values below SYNC_STAGES_MIN are raised to it
// -----------------------------------------------------------------------------
module sync_chain
    import debounce_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    // A chain shorter than the minimum would hand a possibly metastable
    // value straight to the consumer, so the depth is clamped.
    localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [DEPTH-1:0] sync_q;

    // Shift register: bit 0 samples the raw input, bit DEPTH-1 is the output.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Input-conditioning stage: synchronises an asynchronous raw input into the
// clk domain, then accepts a new level only after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles. Produces a clean registered level and
// registered single-cycle edge pulses.
// Ports:
//   clk    in  1  single clock, all logic on posedge
//   clr_n  in  1  asynchronous active-low reset
//   d_raw  in  1  asynchronous raw input (switch / pin)
//   q      out 1  debounced, synchronised level
//   rise   out 1  one-cycle pulse on the edge q goes 0->1
//   fall   out 1  one-cycle pulse on the edge q goes 1->0
//                 (exists only when DEBOUNCE_FALL_EDGE_EN is defined)
// Parameters:
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  stable cycles required to accept a new level (>= 2)
//   CNT_W            stable-counter width (>= $clog2(DEBOUNCE_CYCLES))
// Configuration macro:
//   DEBOUNCE_FALL_EDGE_EN  adds the fall port and its register
// -----------------------------------------------------------------------------
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d_raw,
    output logic q,
`ifdef DEBOUNCE_FALL_EDGE_EN
    output logic rise,
    output logic fall
`else
    output logic rise
`endif
);

    localparam int DB_CYC = (DEBOUNCE_CYCLES < DEBOUNCE_MIN) ? DEBOUNCE_MIN : DEBOUNCE_CYCLES;
    // Terminal count: reaching it with the input still at the new level means
    // the level has been seen on DB_CYC+1 consecutive edges (entry + DB_CYC).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic            s_s;
    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic            fall_q, fall_d;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (d_raw),
        .q     (s_s)
    );

    // Next-state, counter and output-register logic of the debouncer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            IDLE_LO: begin
                cnt_d = '0;
                if (s_s) begin
                    state_d = WAIT_HI;
                end else begin
                    state_d = IDLE_LO;
                end
            end
            WAIT_HI: begin
                // A revert wins even on the terminal cycle.
                if (!s_s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    // Unreachable count: hold rather than wrap.
                    cnt_d   = CNT_LAST;
                end
            end
            IDLE_HI: begin
                cnt_d = '0;
                if (!s_s) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (s_s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
                    fall_d  = 1'b1;
`endif
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = CNT_LAST;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

`ifdef DEBOUNCE_FALL_EDGE_EN
    // Fall pulse register, present only with the fall-edge option.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`endif

    assign q    = level_q;
    assign rise = rise_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
// Self-checking bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference model delays the raw samples by SYNC_STAGES edges and flips
// its level once the delayed input has differed from it on DEBOUNCE_CYCLES+1
// consecutive edges. Build with DEBOUNCE_FALL_EDGE_EN to cover the fall port.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

    localparam int S = 2;
    localparam int D = 4;

    logic clk;
    logic clr_n;
    logic d_raw;
    logic q;
    logic rise;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic fall;
`endif

    debounce_sync #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .d_raw (d_raw),
        .q     (q),
`ifdef DEBOUNCE_FALL_EDGE_EN
        .rise  (rise),
        .fall  (fall)
`else
        .rise  (rise)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;
    int edge_cnt = 0;

    // reference model state
    bit hist[$];
    bit m_q;
    bit m_rise;
    bit m_fall;
    int run;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(1'b0);
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        run    = 0;
    endtask

    task automatic check_outputs();
        chk_eq("q", q, m_q);
        chk_eq("rise", rise, m_rise);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk_eq("fall", fall, m_fall);
        chk_eq("rise_fall_excl", rise & fall, 1'b0);
`endif
    endtask

    // One clock: drive d at negedge, advance model at posedge, check #1 later.
    task automatic step(input bit d);
        bit s_seen;
        @(negedge clk);
        d_raw = d;
        @(posedge clk);
        edge_cnt++;
        s_seen = hist[0];
        void'(hist.pop_front());
        hist.push_back(d);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s_seen != m_q) begin
            run++;
            if (run == D + 1) begin
                m_q = s_seen;
                run = 0;
                if (m_q) m_rise = 1'b1;
                else     m_fall = 1'b1;
            end
        end else begin
            run = 0;
        end
        #1;
        check_outputs();
    endtask

    // Apply a new held level and measure edges from first sample to q change.
    task automatic latency_check(input string tag, input bit lvl);
        int first_edge;
        int lat;
        bit seen;
        first_edge = edge_cnt + 1;
        lat  = -1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                step(lvl);
                if (q === lvl) begin
                    seen = 1'b1;
                    lat  = edge_cnt - first_edge;
                end
            end
        end
        chk_eq(tag, lat, S + D);
    endtask

    task automatic do_reset_pulse();
        @(negedge clk);
        clr_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0;
        d_raw = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_eq("reset_q", q, 1'b0);
        chk_eq("reset_rise", rise, 1'b0);
        clr_n = 1'b1;

        // clean rise and clean fall latency
        repeat (4) step(1'b0);
        latency_check("rise_latency", 1'b1);
        repeat (3) step(1'b1);
        latency_check("fall_latency", 1'b0);
        repeat (3) step(1'b0);

        // short bounce never reaches q
        repeat (2) step(1'b1);
        repeat (6) step(1'b0);
        chk_eq("bounce_q", q, 1'b0);

        // revert on the terminal count cycle, then a re-rise restarts cleanly
        repeat (D) step(1'b1);
        repeat (S + 3) step(1'b0);
        chk_eq("terminal_revert_q", q, 1'b0);
        latency_check("rerise_latency", 1'b1);

        // shortest accepted pulse: D+1 samples
        latency_check("fall_latency2", 1'b0);
        repeat (D + 1) step(1'b1);
        repeat (S + D + 2) step(1'b0);

        // randomized held segments
        for (int seg = 0; seg < 80; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int j = 0; j < len; j++) step(lvl);
        end

        // asynchronous reset with q high
        repeat (S + D + 3) step(1'b1);
        chk_eq("pre_reset_q", q, 1'b1);
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk_eq("async_reset_q", q, 1'b0);
        chk_eq("async_reset_rise", rise, 1'b0);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk_eq("async_reset_fall", fall, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;

        // reset while waiting discards the partial count
        repeat (S + D + 3) step(1'b0);
        repeat (S + 2) step(1'b1);
        do_reset_pulse();
        repeat (D) step(1'b0);
        chk_eq("mid_wait_reset_q", q, 1'b0);
        latency_check("post_reset_rise_latency", 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_debounce_sync
